// File: rtl/dma_framer_pkg.sv
// Shared state type and length arithmetic for the DMA stream framer.
// Lengths are widened to LEN_XW bits so a header near 2^CNT_W cannot overflow (CNT_W up to 64).
package dma_framer_pkg;

    typedef enum logic [0:0] {
        HDR  = 1'b0,
        DATA = 1'b1
    } state_t;

    localparam int LEN_BEATS = 0;
    localparam int LEN_BYTES = 1;

    localparam int LEN_XW   = 65;
    localparam int KEEP_MAX = 128;

    // bpb is always a power of two, so the divide and modulo reduce to a shift and a mask.
    function automatic logic [LEN_XW-1:0] ceil_beats(input logic [LEN_XW-1:0] len,
                                                     input logic [LEN_XW-1:0] bpb);
        return (len / bpb) + LEN_XW'((len % bpb) != '0);
    endfunction

    function automatic logic [KEEP_MAX-1:0] tail_keep(input logic [LEN_XW-1:0] len,
                                                      input logic [LEN_XW-1:0] bpb);
        logic [LEN_XW-1:0] rem;
        rem = len % bpb;
        if (rem == '0)
            return '1;
        return (KEEP_MAX'(1) << rem) - KEEP_MAX'(1);
    endfunction

endpackage

// File: rtl/dma_axis_reg_slice.sv
// One-stage AXI-Stream register carrying an opaque payload.
// Latency: one cycle from accept to m_vld.
// Backpressure: s_rdy = !m_vld || m_rdy; payload holds while m_vld && !m_rdy.
module dma_axis_reg_slice #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] s_dat,
    input  logic         s_vld,
    output logic         s_rdy,
    output logic [W-1:0] m_dat,
    output logic         m_vld,
    input  logic         m_rdy
);
    // Gated by reset so upstream sees not-ready while held in reset.
    assign s_rdy = reset && (!m_vld || m_rdy);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_vld <= 1'b0;
            m_dat <= '0;
        end else if (s_vld && s_rdy) begin
            m_vld <= 1'b1;
            m_dat <= s_dat;
        end else if (m_rdy) begin
            m_vld <= 1'b0;
        end
    end

endmodule

// File: rtl/dma_stream_framer.sv
// Frames a length-headed stream into AXI-Stream packets with tlast/tkeep.
// Latency: one cycle from input accept to m_valid; one beat per cycle.
// Backpressure: s_ready follows the output register; stalls hold m_data/m_keep/m_last.
module dma_stream_framer
    import dma_framer_pkg::*;
#(
    parameter int DATA_W   = 128,
    parameter int CNT_W    = 32,
    parameter int LEN_UNIT = LEN_BEATS,
    parameter int HDR_PASS = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [DATA_W-1:0]   s_data,
    input  logic                s_valid,
    output logic                s_ready,
    output logic [DATA_W-1:0]   m_data,
    output logic                m_valid,
    input  logic                m_ready,
    output logic                m_last,
    output logic [DATA_W/8-1:0] m_keep,
    output logic [31:0]         pkt_cnt,
    output logic                zero_len_err,
    output logic                busy
);
    localparam int BPB = DATA_W / 8;
    localparam int PW  = DATA_W + BPB + 1;
    localparam int RW  = CNT_W + 1;

    state_t            state;
    logic [RW-1:0]     remaining;
    logic [BPB-1:0]    last_keep;
    logic [LEN_XW-1:0] len_x;
    logic [RW-1:0]     beats;
    logic [BPB-1:0]    hdr_keep;
    logic              slice_rdy;
    logic              accept;
    logic              fwd;
    logic              beat_last;
    logic [BPB-1:0]    beat_keep;

    assign len_x = LEN_XW'(s_data[CNT_W-1:0]);
    assign beats = (LEN_UNIT == LEN_BYTES) ? RW'(ceil_beats(len_x, LEN_XW'(BPB)))
                                           : RW'(len_x);
    assign hdr_keep = (LEN_UNIT == LEN_BYTES) ? BPB'(tail_keep(len_x, LEN_XW'(BPB)))
                                              : {BPB{1'b1}};

    assign accept  = s_valid && slice_rdy;
    assign s_ready = slice_rdy;

    // Zero-length headers are swallowed even when headers are otherwise forwarded.
    assign fwd       = (state == DATA) || ((HDR_PASS != 0) && (beats != '0));
    assign beat_last = (state == DATA) && (remaining == RW'(1));
    assign beat_keep = beat_last ? last_keep : {BPB{1'b1}};

    dma_axis_reg_slice #(
        .W(PW)
    ) u_out (
        .clk   (clk),
        .reset (reset),
        .s_dat ({s_data, beat_keep, beat_last}),
        .s_vld (s_valid && fwd),
        .s_rdy (slice_rdy),
        .m_dat ({m_data, m_keep, m_last}),
        .m_vld (m_valid),
        .m_rdy (m_ready)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= HDR;
            remaining    <= '0;
            last_keep    <= '0;
            pkt_cnt      <= '0;
            zero_len_err <= 1'b0;
        end else if (accept) begin
            if (state == HDR) begin
                if (beats == '0) begin
                    zero_len_err <= 1'b1;
                end else begin
                    remaining <= beats;
                    last_keep <= hdr_keep;
                    state     <= DATA;
                end
            end else begin
                remaining <= remaining - RW'(1);
                if (beat_last) begin
                    state   <= HDR;
                    pkt_cnt <= pkt_cnt + 32'd1;
                end
            end
        end
    end

    assign busy = (state == DATA);

endmodule

// File: doc/dma_stream_framer.md
Name: dma_stream_framer

Overview:
- Parametrised successor of the DMA length-header converter; sits between a compute block's output stream and the DMA S2MM AXI-Stream port.
- Consumes a stream whose first beat of each packet carries a length header. Emits an AXI-Stream with correct tlast/tkeep per packet.
- Adds over the previous generation:
  - configurable data width;
  - byte- or beat-granular lengths, with partial tkeep on the final beat;
  - optional header strip/forward;
  - full backpressure through a registered output stage;
  - zero-length detection and packet counting.

Parameters:
- DATA_W, 128: stream width in bits; a multiple of 8 and at least 32. BPB = DATA_W/8, a power of two.
- CNT_W, 32: header length field width, taken from s_data[CNT_W-1:0]; CNT_W ≤ DATA_W.
- LEN_UNIT, 0: 0 = length counts payload beats; 1 = length counts payload bytes.
- HDR_PASS, 0: 0 = header beat is consumed and not forwarded; 1 = header is forwarded as the first output beat and is not counted in the length.

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-low reset.
- s_data  in  DATA_W  input stream data.
- s_valid  in  1  input valid.
- s_ready  out  1  input ready.
- m_data  out  DATA_W  output data, registered.
- m_valid  out  1  output valid.
- m_ready  in  1  downstream ready.
- m_last  out  1  final beat of the packet.
- m_keep  out  DATA_W/8  byte enables; bit i covers m_data[8i+7:8i].
- pkt_cnt  out  32  count of completed packets; wraps modulo 2^32.
- zero_len_err  out  1  sticky flag: a zero-length header was seen.
- busy  out  1  high while in the DATA state.

Behaviour:
- Reset:
  - While reset=0: m_data, m_valid, m_last, m_keep, pkt_cnt, zero_len_err, busy and remaining are all 0; FSM is in HDR; s_ready=0.
  - Assertion clears state immediately (asynchronous). Deassertion takes effect at the next clk edge.
- Handshake and latency:
  - Accept on s_valid && s_ready, where s_ready = !m_valid || m_ready.
  - Latency is 1 cycle, input accept to m_valid; throughput is 1 beat/cycle.
  - m_data, m_last and m_keep hold stable while m_valid && !m_ready.
  - m_valid drops after an output handshake if no new beat is accepted in the same cycle.
- FSM state HDR (accepted beat is a header):
  - len = s_data[CNT_W-1:0].
  - beats = LEN_UNIT ? ceil(len/BPB) : len. Compute in CNT_W+1 bits so len near 2^CNT_W does not overflow.
  - Latch last_keep: rem = len mod BPB; LEN_UNIT=1 and rem≠0 gives (1<<rem)-1 (low lanes valid); otherwise all ones.
  - If beats==0: header is dropped even when HDR_PASS=1; zero_len_err is set; stay in HDR; pkt_cnt unchanged.
  - Otherwise: remaining ← beats; go to DATA. If HDR_PASS=1, output the header with m_keep all ones and m_last=0.
- FSM state DATA (each accepted beat is forwarded):
  - If remaining ≠ 1: m_keep all ones, m_last=0, remaining−1.
  - If remaining == 1: m_last=1, m_keep=last_keep, go to HDR, pkt_cnt+1. The next accepted beat is a new header.
  - Back-to-back packets need no idle cycle.
- Reset mid-packet: the rest of the packet is lost. Upstream must restart at a header; no recovery is attempted.
- busy = (state==DATA).
- Upper header bits above CNT_W are ignored.

Decomposition:
- Package dma_framer_pkg:
  - state enum {HDR, DATA};
  - LEN_BEATS/LEN_BYTES constants;
  - function ceil_beats(len, BPB);
  - function tail_keep(len, BPB).
- Sub-module dma_axis_reg_slice: one-stage AXI-Stream register, parametrised on payload width, carrying {data, keep, last}. It owns s_ready generation and output stability.
- The framer itself holds the FSM, remaining counter, last_keep, pkt_cnt and err.

Test Plan:
- LEN_UNIT=0, HDR_PASS=0, m_ready=1; header 3, then payloads A,B,C back-to-back -> 3 output beats on consecutive cycles; m_last only on C; m_keep=16'hFFFF; pkt_cnt=1.
- LEN_UNIT=1; header 37, then 3 beats -> m_last on beat 3 with m_keep=16'h001F; header 64, then 4 beats -> last beat m_keep=16'hFFFF.
- HDR_PASS=1, LEN_UNIT=0; header 2, then D0,D1 -> outputs hdr (keep FFFF, last 0), D0, D1 (last 1); pkt_cnt increments once.
- Header 0, then header 1, then X -> zero header produces no output and sets zero_len_err=1 (stays set); X is output with m_last=1; pkt_cnt=1.
- 10-beat packet with m_ready toggled pseudo-randomly -> all 10 beats in order, none duplicated; outputs stable while stalled; s_ready=0 whenever m_valid && !m_ready.
- Header 4, one payload accepted, then reset pulsed low -> outputs and counters are 0 during reset; the first beat after release is treated as a header (value 2 gives a 2-beat packet).
